// File: rtl/washer_seq_ctrl.sv
// Programmable washer sequencer: fill/wash/drain rounds, spin, final drain, door pause/resume, done pulse.
// Optional macro FILL_DRAIN_TIMEOUT_EN adds fill/drain timeouts with a sticky coded fault; without it FAULT is unreachable.
module washer_seq_ctrl #(
    parameter int TW          = 8,
    parameter int RW          = 3,
    parameter int T_FILL_MAX  = 200,
    parameter int T_DRAIN_MAX = 200
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          cancel,
    input  logic          door_open,
    input  logic          water_full,
    input  logic          drained,
    input  logic          dry_sensor,
    input  logic [TW-1:0] cfg_wash_time,
    input  logic [TW-1:0] cfg_spin_time,
    input  logic [RW-1:0] cfg_rounds,
    output logic          water_fill,
    output logic          motor_wash,
    output logic          motor_spin,
    output logic          drain,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic          done,
    output logic [2:0]    phase,
    output logic [RW-1:0] rounds_left
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WASH   = 3'd2,
        S_DRAIN  = 3'd3,
        S_SPIN   = 3'd4,
        S_FDRAIN = 3'd5,
        S_PAUSE  = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [RW-1:0] R_ONE     = RW'(1);
    localparam logic [TW-1:0] FILL_LIM  = TW'(T_FILL_MAX);
    localparam logic [TW-1:0] DRAIN_LIM = TW'(T_DRAIN_MAX);

    state_t        state;
    state_t        saved_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] wash_len;
    logic [TW-1:0] spin_len;
    logic [TW-1:0] cnt_lim;
    logic [TW-1:0] timer_up;
    logic [TW-1:0] timer_dn;
    logic          fill_to;
    logic          drain_to;
    logic          timeout;

    // Up-counting phases saturate at their timeout limit; countdown phases floor at zero.
    assign cnt_lim  = (state == S_FILL) ? FILL_LIM : DRAIN_LIM;
    assign timer_up = (timer >= cnt_lim) ? timer : timer + T_ONE;
    assign timer_dn = (timer == '0) ? timer : timer - T_ONE;

`ifdef FILL_DRAIN_TIMEOUT_EN
    localparam logic [TW-1:0] FILL_LAST  = TW'(T_FILL_MAX - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(T_DRAIN_MAX - 1);

    assign fill_to  = (state == S_FILL) && !water_full && (timer >= FILL_LAST);
    assign drain_to = ((state == S_DRAIN) || (state == S_FDRAIN)) && !drained && (timer >= DRAIN_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else if (cancel && (state != S_IDLE)) begin
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else if (fill_to) begin
            fault      <= 1'b1;
            fault_code <= 2'd1;
        end else if (drain_to) begin
            fault      <= 1'b1;
            fault_code <= 2'd2;
        end
    end
`else
    assign fill_to    = 1'b0;
    assign drain_to   = 1'b0;
    assign fault      = 1'b0;
    assign fault_code = 2'd0;
`endif

    assign timeout = fill_to || drain_to;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            saved_state <= S_IDLE;
            timer       <= '0;
            wash_len    <= T_ONE;
            spin_len    <= T_ONE;
            rounds_left <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start && !cancel && !door_open) begin
                    state       <= S_FILL;
                    timer       <= '0;
                    wash_len    <= (cfg_wash_time == '0) ? T_ONE : cfg_wash_time;
                    spin_len    <= (cfg_spin_time == '0) ? T_ONE : cfg_spin_time;
                    rounds_left <= (cfg_rounds == '0) ? R_ONE : cfg_rounds;
                end
            end else if (cancel) begin
                state       <= S_IDLE;
                timer       <= '0;
                rounds_left <= '0;
            end else if (timeout) begin
                state <= S_FAULT;
            end else if (door_open && (state != S_PAUSE) && (state != S_FAULT)) begin
                // The cycle in which the door opens still counts; any completion is re-judged on resume.
                saved_state <= state;
                state       <= S_PAUSE;
                if ((state == S_WASH) || (state == S_SPIN)) begin
                    timer <= timer_dn;
                end else begin
                    timer <= timer_up;
                end
            end else begin
                case (state)
                    S_FILL: begin
                        if (water_full) begin
                            state <= S_WASH;
                            timer <= wash_len;
                        end else begin
                            timer <= timer_up;
                        end
                    end
                    S_WASH: begin
                        if (timer <= T_ONE) begin
                            state <= S_DRAIN;
                            timer <= '0;
                        end else begin
                            timer <= timer_dn;
                        end
                    end
                    S_DRAIN: begin
                        if (drained) begin
                            if (rounds_left > R_ONE) begin
                                rounds_left <= rounds_left - R_ONE;
                                state       <= S_FILL;
                                timer       <= '0;
                            end else begin
                                state <= S_SPIN;
                                timer <= spin_len;
                            end
                        end else begin
                            timer <= timer_up;
                        end
                    end
                    S_SPIN: begin
                        if (dry_sensor || (timer <= T_ONE)) begin
                            state <= S_FDRAIN;
                            timer <= '0;
                        end else begin
                            timer <= timer_dn;
                        end
                    end
                    S_FDRAIN: begin
                        if (drained) begin
                            state       <= S_IDLE;
                            timer       <= '0;
                            rounds_left <= '0;
                            done        <= 1'b1;
                        end else begin
                            timer <= timer_up;
                        end
                    end
                    S_PAUSE: begin
                        if (!door_open) begin
                            state <= saved_state;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign phase      = state;
    assign water_fill = (state == S_FILL);
    assign motor_wash = (state == S_WASH);
    assign motor_spin = (state == S_SPIN);
    assign drain      = (state == S_DRAIN) || (state == S_FDRAIN);

endmodule
